fpmult_issue_arbiter: RTL and testbench

FPMULT_ISSUE_ARBITER -- requirements
Module: fpmult_issue_arbiter

---
 rtl/fpmult_issue_arbiter_if.sv | 37 +++
 rtl/fpmult_issue_arbiter.sv | 117 +++++++++++
 tb/tb_fpmult_issue_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmult_issue_arbiter_if.sv
// Request/issue/result bundle between four FP-multiply requesters, the issue arbiter and the shared multiplier.
// grant_cnt is only present when FPMULT_ARB_PERF_EN is defined.
interface fpmult_issue_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic               mult_valid;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic [WIDTH-1:0]   mult_result;
    logic [3:0]         res_valid;
    logic [WIDTH-1:0]   res_data;
`ifdef FPMULT_ARB_PERF_EN
    logic [4*16-1:0]    grant_cnt;

    modport slave (
        input  req_valid, req_a, req_b, mult_result,
        output req_ready, mult_valid, mult_a, mult_b, res_valid, res_data, grant_cnt
    );
    modport master (
        output req_valid, req_a, req_b, mult_result,
        input  req_ready, mult_valid, mult_a, mult_b, res_valid, res_data, grant_cnt
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, mult_result,
        output req_ready, mult_valid, mult_a, mult_b, res_valid, res_data
    );
    modport master (
        output req_valid, req_a, req_b, mult_result,
        input  req_ready, mult_valid, mult_a, mult_b, res_valid, res_data
    );
`endif
endinterface

// File: rtl/fpmult_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FP multiplier among four requesters, with per-requester
// in-flight limits and result routing by tag. Define FPMULT_ARB_PERF_EN to add saturating grant counters.
module fpmult_issue_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fpmult_issue_arbiter_if.slave bus
);
    logic [1:0]       pointer;
    logic [2:0]       outstanding [4];
    logic [3:0]       eligible;
    logic [3:0]       grant;
    logic [1:0]       grantId;
    logic [1:0]       scanIdx;
    logic             accept;
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;
    logic [WIDTH-1:0] multA;
    logic [WIDTH-1:0] multB;
    logic [LATENCY:0] tagValid;
    logic [1:0]       tagId [LATENCY+1];
    logic [3:0]       resValid;
    logic [WIDTH-1:0] resData;

    // A result returning this cycle frees its slot, so the owner may be re-granted in the same cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = bus.req_valid[i] &&
                          ((outstanding[i] - {2'b00, resValid[i]}) < 3'(MAX_OUT));
        end
    end

    // Scan from lowest priority up so the highest-priority eligible requester is written last.
    always_comb begin
        grant   = 4'b0000;
        grantId = pointer;
        scanIdx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scanIdx = pointer + 2'(k);
            if (eligible[scanIdx]) begin
                grant   = 4'b0001 << scanIdx;
                grantId = scanIdx;
            end
        end
    end

    assign accept = |grant;

    always_comb begin
        selA = '0;
        selB = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                selA = bus.req_a[i*WIDTH +: WIDTH];
                selB = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Tag stage 0 doubles as the issue strobe; stage LATENCY lines up with mult_result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pointer  <= '0;
            tagValid <= '0;
            multA    <= '0;
            multB    <= '0;
            resValid <= '0;
            resData  <= '0;
            for (int i = 0; i < 4; i++) outstanding[i] <= '0;
            for (int s = 0; s <= LATENCY; s++) tagId[s] <= '0;
        end else begin
            if (accept) begin
                pointer <= grantId + 2'd1;
                multA   <= selA;
                multB   <= selB;
            end
            tagValid <= {tagValid[LATENCY-1:0], accept};
            tagId[0] <= grantId;
            for (int s = 1; s <= LATENCY; s++) tagId[s] <= tagId[s-1];
            resValid <= tagValid[LATENCY] ? (4'b0001 << tagId[LATENCY]) : 4'b0000;
            if (tagValid[LATENCY]) resData <= bus.mult_result;
            for (int i = 0; i < 4; i++) begin
                case ({grant[i], resValid[i]})
                    2'b10:   outstanding[i] <= outstanding[i] + 3'd1;
                    2'b01:   outstanding[i] <= outstanding[i] - 3'd1;
                    default: outstanding[i] <= outstanding[i];
                endcase
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.mult_valid = tagValid[0];
    assign bus.mult_a     = multA;
    assign bus.mult_b     = multB;
    assign bus.res_valid  = resValid;
    assign bus.res_data   = resData;

`ifdef FPMULT_ARB_PERF_EN
    logic [15:0] grantCnt [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) grantCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i] && (grantCnt[i] != 16'hFFFF)) grantCnt[i] <= grantCnt[i] + 16'd1;
            end
        end
    end

    assign bus.grant_cnt = {grantCnt[3], grantCnt[2], grantCnt[1], grantCnt[0]};
`endif
endmodule

// File: tb/tb_fpmult_issue_arbiter.sv
// Directed bench for fpmult_issue_arbiter: a LATENCY=4 instance for most scenarios, a LATENCY=8 instance
// for the fairness/saturation case, and (with FPMULT_ARB_PERF_EN) a MAX_OUT=7 instance for grant counting.
module tb_fpmult_issue_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    fpmult_issue_arbiter_if #(.WIDTH(W)) bus ();
    fpmult_issue_arbiter_if #(.WIDTH(W)) bus8 ();

    fpmult_issue_arbiter #(.WIDTH(W), .LATENCY(4), .MAX_OUT(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fpmult_issue_arbiter #(.WIDTH(W), .LATENCY(8), .MAX_OUT(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // Multiplier stand-in: result = a + b, delivered LATENCY cycles after the issue cycle.
    logic [W-1:0] pipe4 [4];
    logic [W-1:0] pipe8 [8];
    always @(posedge clk) begin
        pipe4[0] <= bus.mult_a + bus.mult_b;
        for (int s = 1; s < 4; s++) pipe4[s] <= pipe4[s-1];
        pipe8[0] <= bus8.mult_a + bus8.mult_b;
        for (int s = 1; s < 8; s++) pipe8[s] <= pipe8[s-1];
    end
    assign bus.mult_result  = pipe4[3];
    assign bus8.mult_result = pipe8[7];

`ifdef FPMULT_ARB_PERF_EN
    fpmult_issue_arbiter_if #(.WIDTH(W)) busP ();
    fpmult_issue_arbiter #(.WIDTH(W), .LATENCY(4), .MAX_OUT(7)) dutP (.clk(clk), .rst(rst), .bus(busP));
    logic [W-1:0] pipeP [4];
    always @(posedge clk) begin
        pipeP[0] <= busP.mult_a + busP.mult_b;
        for (int s = 1; s < 4; s++) pipeP[s] <= pipeP[s-1];
    end
    assign busP.mult_result = pipeP[3];
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid  = 4'b0000;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus8.req_valid = 4'b0000;
        bus8.req_a     = '0;
        bus8.req_b     = '0;
`ifdef FPMULT_ARB_PERF_EN
        busP.req_valid = 4'b0000;
        busP.req_a     = '0;
        busP.req_b     = '0;
`endif
    endtask

    // Leaves the bench 1ns after a rising edge with rst high: the next edge is the first active one.
    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        #2;
        checks++; if (bus.mult_valid !== 1'b0) begin failures++; $display("FAIL reset_mult_valid got=%b exp=0", bus.mult_valid); end
        checks++; if (bus.res_valid !== 4'b0000) begin failures++; $display("FAIL reset_res_valid got=%b exp=0000", bus.res_valid); end
        checks++; if (bus.mult_a !== 32'h0) begin failures++; $display("FAIL reset_mult_a got=%h exp=0", bus.mult_a); end
        checks++; if (bus.res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", bus.res_data); end
`ifdef FPMULT_ARB_PERF_EN
        checks++; if (bus.grant_cnt !== 64'h0) begin failures++; $display("FAIL reset_grant_cnt got=%h exp=0", bus.grant_cnt); end
`endif
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_ready got=%b exp=0001", bus.req_ready); end
        bus.req_valid = 4'b0000;
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_a = {96'hDEADBEEF_12345678_CAFEF00D, 32'h40000000};
        bus.req_b = {96'h0BADF00D_87654321_FEEDFACE, 32'h40400000};
        #2;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
        cyc();
        bus.req_valid = 4'b0000;
        #2;
        checks++; if (bus.mult_valid !== 1'b1) begin failures++; $display("FAIL single_mult_valid got=%b exp=1", bus.mult_valid); end
        checks++; if (bus.mult_a !== 32'h40000000) begin failures++; $display("FAIL single_mult_a got=%h exp=40000000", bus.mult_a); end
        checks++; if (bus.mult_b !== 32'h40400000) begin failures++; $display("FAIL single_mult_b got=%h exp=40400000", bus.mult_b); end
        for (int k = 2; k <= 7; k++) begin
            cyc();
            #2;
            checks++;
            if (bus.res_valid !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL single_res_valid k=%0d got=%b exp=%b", k, bus.res_valid, (k == 6) ? 4'b0001 : 4'b0000);
            end
            if (k == 6) begin
                checks++; if (bus.res_data !== 32'h80400000) begin failures++; $display("FAIL single_res_data got=%h exp=80400000", bus.res_data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expA [4];
        logic [31:0] expB [4];
        logic [31:0] expSum [4];
        expA   = '{32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h3F800003};
        expB   = '{32'h40000000, 32'h40000010, 32'h40000020, 32'h40000030};
        expSum = '{32'h7F800000, 32'h7F800011, 32'h7F800022, 32'h7F800033};
        do_reset();
        bus.req_a = {32'h3F800003, 32'h3F800002, 32'h3F800001, 32'h3F800000};
        bus.req_b = {32'h40000030, 32'h40000020, 32'h40000010, 32'h40000000};
        for (int k = 0; k <= 10; k++) begin
            bus.req_valid = (k < 4) ? 4'b1111 : 4'b0000;
            #2;
            if (k < 4) begin
                checks++; if (bus.req_ready !== (4'b0001 << k)) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus.req_ready, 4'b0001 << k); end
            end
            if (k >= 1 && k <= 4) begin
                checks++; if (bus.mult_valid !== 1'b1) begin failures++; $display("FAIL b2b_mult_valid k=%0d got=%b exp=1", k, bus.mult_valid); end
                checks++; if (bus.mult_a !== expA[k-1]) begin failures++; $display("FAIL b2b_mult_a k=%0d got=%h exp=%h", k, bus.mult_a, expA[k-1]); end
                checks++; if (bus.mult_b !== expB[k-1]) begin failures++; $display("FAIL b2b_mult_b k=%0d got=%h exp=%h", k, bus.mult_b, expB[k-1]); end
            end
            if (k == 5) begin
                checks++; if (bus.mult_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%b exp=0", bus.mult_valid); end
                checks++; if (bus.mult_a !== 32'h3F800003) begin failures++; $display("FAIL b2b_hold_a got=%h exp=3f800003", bus.mult_a); end
            end
            if (k >= 6 && k <= 9) begin
                checks++; if (bus.res_valid !== (4'b0001 << (k-6))) begin failures++; $display("FAIL b2b_res_valid k=%0d got=%b exp=%b", k, bus.res_valid, 4'b0001 << (k-6)); end
                checks++; if (bus.res_data !== expSum[k-6]) begin failures++; $display("FAIL b2b_res_data k=%0d got=%h exp=%h", k, bus.res_data, expSum[k-6]); end
            end
            if (k == 10) begin
                checks++; if (bus.res_valid !== 4'b0000) begin failures++; $display("FAIL b2b_res_end got=%b exp=0000", bus.res_valid); end
            end
            cyc();
        end
    endtask

    // LATENCY=8 instance: the round trip is 10 cycles, so all eight slots fill before any result returns.
    task automatic test_fairness();
        logic [3:0] expReady [11];
        expReady = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1};
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            bus8.req_valid = 4'b1111;
            #2;
            checks++; if (bus8.req_ready !== expReady[k]) begin failures++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, bus8.req_ready, expReady[k]); end
            checks++; if (bus8.res_valid !== ((k == 10) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL fair_res_valid k=%0d got=%b", k, bus8.res_valid); end
            cyc();
        end
        bus8.req_valid = 4'b0000;
    endtask

    task automatic test_limit();
        logic [3:0] expReady [9];
        logic [3:0] expRes [9];
        expReady = '{4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
        expRes   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            bus.req_valid = 4'b0100;
            #2;
            checks++; if (bus.req_ready !== expReady[k]) begin failures++; $display("FAIL limit_ready k=%0d got=%b exp=%b", k, bus.req_ready, expReady[k]); end
            checks++; if (bus.res_valid !== expRes[k]) begin failures++; $display("FAIL limit_res k=%0d got=%b exp=%b", k, bus.res_valid, expRes[k]); end
            cyc();
        end
        bus.req_valid = 4'b0000;
    endtask

    // Cycle 6: requester 1 at two in flight both returns a result and is re-granted; it must stay at two.
    task automatic test_simultaneous();
        logic [3:0] vecValid [13];
        logic [3:0] expReady [13];
        logic [3:0] expRes [13];
        vecValid = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
        expReady = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2};
        expRes   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            bus.req_valid = vecValid[k];
            #2;
            checks++; if (bus.req_ready !== expReady[k]) begin failures++; $display("FAIL simul_ready k=%0d got=%b exp=%b", k, bus.req_ready, expReady[k]); end
            checks++; if (bus.res_valid !== expRes[k]) begin failures++; $display("FAIL simul_res k=%0d got=%b exp=%b", k, bus.res_valid, expRes[k]); end
            cyc();
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.req_valid = 4'b1111;
        cyc();
        cyc();
        cyc();
        bus.req_valid = 4'b0000;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int k = 4; k <= 14; k++) begin
            #2;
            checks++; if (bus.res_valid !== 4'b0000) begin failures++; $display("FAIL midrst_res k=%0d got=%b exp=0000", k, bus.res_valid); end
            cyc();
        end
        bus.req_valid = 4'b1111;
        #2;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ready got=%b exp=0001", bus.req_ready); end
        bus.req_valid = 4'b0000;
        cyc();
    endtask

`ifdef FPMULT_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        busP.req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) cyc();
        #2;
        checks++; if (busP.grant_cnt !== {48'h0, 16'd10}) begin failures++; $display("FAIL perf_cnt10 got=%h exp=%h", busP.grant_cnt, {48'h0, 16'd10}); end
        for (int k = 10; k < 70000; k++) cyc();
        #2;
        checks++; if (busP.grant_cnt !== {48'h0, 16'hFFFF}) begin failures++; $display("FAIL perf_sat got=%h exp=%h", busP.grant_cnt, {48'h0, 16'hFFFF}); end
        busP.req_valid = 4'b0000;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_limit();
        test_simultaneous();
        test_reset_midflight();
`ifdef FPMULT_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
